// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the seven-segment scanner:
//   - slot index constants (SLOT_SD0..SLOT_HR1), scan order sd0 first
//   - two-state per-slot FSM encoding (BLANK / SHOW)
//   - blank segment pattern
//   - digit-select helpers honouring the digit polarity
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    localparam int unsigned NUM_SLOTS = 6;

    localparam logic [2:0] SLOT_SD0 = 3'd0;
    localparam logic [2:0] SLOT_SD1 = 3'd1;
    localparam logic [2:0] SLOT_MN0 = 3'd2;
    localparam logic [2:0] SLOT_MN1 = 3'd3;
    localparam logic [2:0] SLOT_HR0 = 3'd4;
    localparam logic [2:0] SLOT_HR1 = 3'd5;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Digit-select word with only slot idx active.
    function automatic logic [5:0] dig_select(input logic [2:0] idx, input logic act_low);
        logic [5:0] onehot;
        onehot = 6'b00_0001 << idx;
        return act_low ? ~onehot : onehot;
    endfunction

    // Digit-select word with every digit inactive.
    function automatic logic [5:0] dig_idle(input logic act_low);
        return {6{act_low}};
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scan_if
// Bundle between the six static segment decoders and the display drivers.
//   hr1..sd0 : 8-bit segment patterns from the decoders
//   seg      : shared segment bus
//   dig      : digit select, bit i selects slot i
//   frame    : one-cycle pulse on the first cycle of a new frame
// Modports:
//   master : decoder/bench side, drives patterns, observes outputs
//   slave  : scanner side, consumes patterns, drives seg/dig/frame
// -----------------------------------------------------------------------------
interface seg_scan_if;

    logic [7:0] hr1;
    logic [7:0] hr0;
    logic [7:0] mn1;
    logic [7:0] mn0;
    logic [7:0] sd1;
    logic [7:0] sd0;
    logic [7:0] seg;
    logic [5:0] dig;
    logic       frame;

    modport master (
        output hr1, hr0, mn1, mn0, sd1, sd0,
        input  seg, dig, frame
    );

    modport slave (
        input  hr1, hr0, mn1, mn0, sd1, sd0,
        output seg, dig, frame
    );

endinterface

// File: rtl/seg_scan_timer.sv
// -----------------------------------------------------------------------------
// seg_scan_timer
// Slot counter (cnt, 0..scan_div-1) and slot index (idx, 0..5) for the scanner.
// Exposes the next-cycle values so the parent can register outputs that line
// up with the current counters without extra latency.
// Ports:
//   clk          : system clock
//   rst          : asynchronous active-high reset
//   cnt_d_o      : cnt value for the next cycle
//   idx_d_o      : idx value for the next cycle
//   slot_wrap_o  : current cycle is the last of its slot
//   frame_edge_o : current cycle is the last of the frame (idx 5, last cnt)
// -----------------------------------------------------------------------------
module seg_scan_timer #(
    parameter logic [27:0] scan_div = 28'd1_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [27:0] cnt_d_o,
    output logic [2:0]  idx_d_o,
    output logic        slot_wrap_o,
    output logic        frame_edge_o
);
    import seg_scan_pkg::*;

    localparam logic [27:0] CNT_LAST = scan_div - 28'd1;

    logic [27:0] cnt_q;
    logic [27:0] cnt_d;
    logic [2:0]  idx_q;
    logic [2:0]  idx_d;
    logic        slot_wrap;
    logic        frame_edge;

    always_comb begin
        slot_wrap  = (cnt_q == CNT_LAST);
        frame_edge = slot_wrap && (idx_q == SLOT_HR1);
        cnt_d      = slot_wrap ? '0 : cnt_q + 28'd1;
        idx_d      = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == SLOT_HR1) ? SLOT_SD0 : idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= SLOT_SD0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt_d_o      = cnt_d;
    assign idx_d_o      = idx_d;
    assign slot_wrap_o  = slot_wrap;
    assign frame_edge_o = frame_edge;

endmodule

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan
// Time-multiplexed seven-segment scanner. Snapshots the six segment patterns
// at every frame edge and drives them one slot at a time onto a shared
// segment bus with a matching digit select.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : seg_scan_if.slave (hr1..sd0 in; seg, dig, frame out)
// Parameters:
//   scan_div    : cycles per digit slot (>= 2)
//   blank_cyc   : blanking cycles at slot start (1 <= blank_cyc < scan_div)
//   dig_act_low : 1 = digit selected when its dig bit is 0
// Configuration macro:
//   SEG_SCAN_BLANK_EN : when defined, each slot starts with blank_cyc cycles of
//                       BLANK (all digits off) before SHOW; when undefined,
//                       every slot is SHOW for its full length.
// -----------------------------------------------------------------------------
module seg_scan #(
    parameter logic [27:0] scan_div    = 28'd1_000,
    parameter logic [27:0] blank_cyc   = 28'd16,
    parameter logic        dig_act_low = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    seg_scan_if.slave    bus
);
    import seg_scan_pkg::*;

    logic [27:0] cnt_d;
    logic [2:0]  idx_d;
    logic        slot_wrap;
    logic        frame_edge;

    seg_scan_timer #(
        .scan_div (scan_div)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .cnt_d_o      (cnt_d),
        .idx_d_o      (idx_d),
        .slot_wrap_o  (slot_wrap),
        .frame_edge_o (frame_edge)
    );

    // ---------------------------------------------------------------------
    // Input snapshot, indexed by slot number
    // ---------------------------------------------------------------------
    logic [7:0] pat_in [NUM_SLOTS];
    logic [7:0] snap_q [NUM_SLOTS];
    logic [7:0] view   [NUM_SLOTS];

    assign pat_in[SLOT_SD0] = bus.sd0;
    assign pat_in[SLOT_SD1] = bus.sd1;
    assign pat_in[SLOT_MN0] = bus.mn0;
    assign pat_in[SLOT_MN1] = bus.mn1;
    assign pat_in[SLOT_HR0] = bus.hr0;
    assign pat_in[SLOT_HR1] = bus.hr1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                snap_q[i] <= '0;
            end
        end else if (frame_edge) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                snap_q[i] <= pat_in[i];
            end
        end
    end

    // At the frame edge the output register loads alongside the snapshot, so
    // it must see the incoming patterns rather than the outgoing snapshot.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            view[i] = frame_edge ? pat_in[i] : snap_q[i];
        end
    end

    // ---------------------------------------------------------------------
    // Per-slot FSM; state_d describes the cycle the outputs are loaded for
    // ---------------------------------------------------------------------
    scan_state_e state_q;
    scan_state_e state_d;

`ifdef SEG_SCAN_BLANK_EN
    localparam scan_state_e ST_RESET = ST_BLANK;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BLANK: if (cnt_d == blank_cyc) state_d = ST_SHOW;
            ST_SHOW:  if (slot_wrap)          state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
    end
`else
    localparam scan_state_e ST_RESET = ST_SHOW;

    logic unused_noblank;
    assign unused_noblank = ^{cnt_d, blank_cyc, slot_wrap};

    always_comb begin
        state_d = state_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Output registers, loaded with the values for the next (idx, cnt)
    // ---------------------------------------------------------------------
    logic [7:0] seg_q;
    logic [7:0] seg_d;
    logic [5:0] dig_q;
    logic [5:0] dig_d;
    logic       frame_q;
    logic       frame_d;
    logic [7:0] shown;

    always_comb begin
        shown = SEG_BLANK;
        unique case (idx_d)
            SLOT_SD0: shown = view[SLOT_SD0];
            SLOT_SD1: shown = view[SLOT_SD1];
            SLOT_MN0: shown = view[SLOT_MN0];
            SLOT_MN1: shown = view[SLOT_MN1];
            SLOT_HR0: shown = view[SLOT_HR0];
            SLOT_HR1: shown = view[SLOT_HR1];
            default:  shown = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg_d   = SEG_BLANK;
        dig_d   = dig_idle(dig_act_low);
        frame_d = frame_edge;
        if (state_d == ST_SHOW) begin
            seg_d = shown;
            dig_d = dig_select(idx_d, dig_act_low);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q   <= SEG_BLANK;
            dig_q   <= dig_idle(dig_act_low);
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dig   = dig_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan
// Scoreboard bench for seg_scan with scan_div=4, blank_cyc=1, dig_act_low=1.
// Stimulus pushes the expected seg/dig/frame for each cycle into a queue;
// a monitor on the falling edge pops and compares. Expectations follow
// SEG_SCAN_BLANK_EN so the same bench serves both builds.
// -----------------------------------------------------------------------------
module tb_seg_scan;

`ifdef SEG_SCAN_BLANK_EN
    localparam int BLANK_LEN = 1;
`else
    localparam int BLANK_LEN = 0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [5:0] dig;
        logic       frame;
    } exp_t;

    exp_t       q[$];
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    logic [7:0] in_v   [6];
    logic [7:0] snap_m [6];
    logic [5:0] dig_tbl [6];

    seg_scan_if bus_if ();

    assign bus_if.sd0 = in_v[0];
    assign bus_if.sd1 = in_v[1];
    assign bus_if.mn0 = in_v[2];
    assign bus_if.mn1 = in_v[3];
    assign bus_if.hr0 = in_v[4];
    assign bus_if.hr1 = in_v[5];

    seg_scan #(
        .scan_div    (28'd4),
        .blank_cyc   (28'd1),
        .dig_act_low (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic push(input logic [7:0] s, input logic [5:0] d, input logic f);
        exp_t e;
        e.cyc = cyc; e.seg = s; e.dig = d; e.frame = f;
        q.push_back(e);
    endtask

    // Expected outputs for cycle k after reset release (k=0 still shows the
    // reset values); also captures the snapshot at each frame's last cycle.
    task automatic expect_k(input int k);
        int idx;
        int cnt;
        if (k == 0) begin
            push(8'h00, 6'h3F, 1'b0);
        end else begin
            idx = (k / 4) % 6;
            cnt = k % 4;
            if (cnt < BLANK_LEN) push(8'h00, 6'h3F, (k % 24) == 0);
            else                 push(snap_m[idx], dig_tbl[idx], (k % 24) == 0);
        end
        if ((k % 24) == 23) begin
            for (int i = 0; i < 6; i++) snap_m[i] = in_v[i];
        end
    endtask

    task automatic cmp(input string name, input int c, input logic [7:0] got, input logic [7:0] exp_v);
        checks = checks + 1;
        if (got !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, exp_v);
        end
    endtask

    // Monitor: the DUT presents seg/dig/frame every cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL missed_sample cyc=%0d got=none expected=sample", e.cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            cmp("seg",   cyc, bus_if.seg, e.seg);
            cmp("dig",   cyc, {2'b00, bus_if.dig}, {2'b00, e.dig});
            cmp("frame", cyc, {7'd0, bus_if.frame}, {7'd0, e.frame});
        end
    end

    initial begin
        dig_tbl = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
        for (int i = 0; i < 6; i++) begin
            in_v[i]   = 8'h00;
            snap_m[i] = 8'h00;
        end

        // Reset held with arbitrary inputs.
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 6; i++) in_v[i] = 8'($urandom);
            push(8'h00, 6'h3F, 1'b0);
        end

        // Release with sd0=3F; frame pulses at 24, 48, ...
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) in_v[i] = 8'h00;
        in_v[0] = 8'h3F;
        rst = 1'b0;
        for (int k = 0; k <= 109; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 24) begin
                for (int i = 0; i < 6; i++) in_v[i] = 8'(i + 1);
            end
            if (k == 58) in_v[5] = 8'h7F;   // during slot 2 of the third frame
            expect_k(k);
        end

        // Mid-frame reset in slot 3: outputs go to reset values at once.
        @(posedge clk); #1;
        rst = 1'b1;
        push(8'h00, 6'h3F, 1'b0);
        for (int n = 0; n < 2; n++) begin
            @(posedge clk); #1;
            push(8'h00, 6'h3F, 1'b0);
        end

        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) snap_m[i] = 8'h00;
        for (int k = 0; k < 50; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            expect_k(k);
        end

        @(posedge clk);
        @(negedge clk); #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain got=%0d expected=0 pending", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed seven-segment scanner that sits directly downstream of the six static segment decoders in the clock display path. It takes the six 8-bit segment patterns (hr1..sd0) and drives one shared 8-bit segment bus plus a 6-bit digit-select bus, one digit per time slot. At each frame boundary it snapshots all six inputs, so a frame never mixes old and new time values.

## Interface
- scan_div, default 28'd1_000: clock cycles per digit slot; legal range ≥ 2.
- blank_cyc, default 28'd16: blanking cycles at the start of each slot; legal range 1 ≤ blank_cyc < scan_div; used only with SEG_SCAN_BLANK_EN.
- dig_act_low, default 1: 1 means a digit is selected when its dig bit is 0 (common-anode); 0 means selected when 1.
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- hr1, hr0, mn1, mn0, sd1, sd0  in  8 each  segment patterns, passed to seg unmodified.
- seg  out  8  shared segment bus (registered).
- dig  out  6  digit select (registered); bit i selects slot i.
- frame  out  1  one-cycle pulse marking the first cycle of a new frame (registered).

## Operation
- Slot index idx runs 0..5: 0=sd0, 1=sd1, 2=mn0, 3=mn1, 4=hr0, 5=hr1.
- Slot counter cnt runs 0..scan_div-1.
- When cnt wraps, idx increments; idx wraps from 5 to 0. One frame is 6*scan_div cycles.
- Snapshot registers (six × 8 bits) load all six inputs at the edge ending the cycle where idx==5 and cnt==scan_div-1 (frame edge).
- Input changes at any other time are ignored until the next frame edge.
- States per slot:
  - BLANK: cnt < blank_cyc. All dig bits inactive; seg = 8'h00.
  - SHOW: the remaining cycles of the slot. The dig bit for idx is active, all other dig bits are inactive, and seg = snapshot[idx].
- Transitions: BLANK→SHOW when cnt reaches blank_cyc; SHOW→BLANK at slot wrap.
- Exactly zero or one dig bit is active in any cycle.

## Timing
- seg, dig and frame are registers loaded with the values for the next (idx, cnt). In any cycle they therefore match the current idx/cnt with no extra latency.
- At the frame edge, seg is loaded from the freshly sampled input, not from the stale snapshot.
- frame is 1 for exactly the cycle with idx==0 and cnt==0 that follows a frame edge. It is not asserted in the first frame after reset.
- Reset values: cnt=0, idx=0, snapshot all 8'h00, seg=8'h00, frame=0.
  - dig resets to 6'h3F if dig_act_low, else 6'h00.
  - The FSM resets to BLANK (SHOW when blanking is compiled out).
- The first frame after reset displays the zero snapshot.
- Reset asserted mid-frame returns all of the above to reset values immediately (asynchronously). Scanning restarts at idx 0 on the first edge after release.
- cnt and idx are sized to 28 and 3 bits; no other arithmetic.

## Configuration
- SEG_SCAN_BLANK_EN defined: the BLANK phase is present (anti-ghosting), as described above.
- SEG_SCAN_BLANK_EN undefined: there is no BLANK state; every slot is SHOW for all scan_div cycles, and blank_cyc is ignored.

## Structure
- Shared package holds:
  - slot-index constants (SLOT_SD0..SLOT_HR1)
  - the 2-state FSM enum
  - the blank segment constant 8'h00
- One sub-module, seg_scan_timer, contains the cnt/idx counters and generates the slot-wrap and frame-edge strobes.
- Snapshot registers, the FSM and the output registers stay in seg_scan.

## Test plan
All scenarios use scan_div=4, blank_cyc=1, dig_act_low=1, with SEG_SCAN_BLANK_EN defined unless stated otherwise.
- Reset: hold rst high with arbitrary inputs -> seg=8'h00, dig=6'h3F, frame=0; these hold while rst is high.
- Frame pulse: release rst with sd0=8'h3F -> frame=1 exactly in cycle 24 after release, then every 24 cycles. In cycles 25..27, dig=6'h3E and seg=8'h3F.
- Scan order: distinct inputs 8'h01..8'h06 on sd0..hr1 -> in the second frame the SHOW-phase dig sequence is 3E, 3D, 3B, 37, 2F, 1F, with seg 01..06 respectively. Cycle 0 of each slot gives dig=3F, seg=00.
- Tear-free: change hr1 from 8'h06 to 8'h7F during slot 2 -> slot 5 still shows 8'h06; 8'h7F appears only after the next frame pulse.
- Macro off: with SEG_SCAN_BLANK_EN undefined -> after reset exactly one dig bit is low in every cycle, and each digit is shown for 4 cycles.
- Mid-frame reset: assert rst during slot 3 -> outputs return to reset values immediately; after release, the first dig SHOW value is 6'h3E with seg=8'h00.
